// File: rtl/ovl_pkg.sv
// Shared types and constants for the digit-glyph overlay path.
package ovl_pkg;

    // Result-batch FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PENDING = 2'd2
    } res_state_t;

    // Glyph code that tells the pixel mux to show nothing
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // Default tile geometry for the 480-wide VGA overlay
    localparam int DEF_H_ACT   = 480;
    localparam int DEF_X0      = 428;
    localparam int DEF_Y0      = 0;
    localparam int DEF_TILE    = 50;
    localparam int DEF_NUM_DIG = 4;
    localparam int DEF_ROM_LAT = 2;
    localparam int DEF_ADDR_W  = 14;

    // Raster counters are 10 bits and wrap naturally
    localparam int CNT_W = 10;

    // Per-pixel tag carried alongside the ROM read so it lines up with the data
    typedef struct packed {
        logic       en;
        logic [3:0] glyph;
    } ovl_tag_t;

    localparam ovl_tag_t TAG_NONE = '{en: 1'b0, glyph: GLYPH_BLANK};

    // Committed digits above 9 are shown as blank
    function automatic logic [3:0] glyph_of(input logic [3:0] digit);
        return (digit > 4'd9) ? GLYPH_BLANK : digit;
    endfunction

endpackage

// File: rtl/ovl_raster_cnt.sv
// Raster position counters, vsync rising-edge pulse and look-ahead tile-window decode.
// The decode looks at the position the counters will hold next cycle, advanced by ROM_LAT
// columns, so the address register in the top level lines up with the counters.
module ovl_raster_cnt
    import ovl_pkg::*;
#(
    parameter int H_ACT   = DEF_H_ACT,
    parameter int X0      = DEF_X0,
    parameter int Y0      = DEF_Y0,
    parameter int TILE    = DEF_TILE,
    parameter int NUM_DIG = DEF_NUM_DIG,
    parameter int ROM_LAT = DEF_ROM_LAT,
    parameter int TW      = 2
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             vga_vsync,
    input  logic             vga_hsync,
    input  logic             active_video,
    output logic             vs_rise,
    output logic             la_win,
    output logic [TW-1:0]    la_tile,
    output logic             la_tile_top,
    output logic             la_tile_bot,
    output logic             la_row_end,
    output logic [CNT_W-1:0] la_x_off
);

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col_d;
    logic [CNT_W-1:0] row_d;
    logic [CNT_W-1:0] px;
    logic [CNT_W-1:0] rel_row;
    logic             vsync_q;
    logic             x_hit;
    logic             y_hit;

    // Next raster position: syncs clear, active pixels advance
    always_comb begin
        col_d = col;
        row_d = row;
        if (vga_hsync) begin
            col_d = '0;
        end else if (active_video) begin
            col_d = col + 1'b1;
        end
        if (vga_vsync) begin
            row_d = '0;
        end else if (active_video && (col == CNT_W'(H_ACT - 1))) begin
            row_d = row + 1'b1;
        end
    end

    // Raster position and vsync history registers
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            col     <= '0;
            row     <= '0;
            vsync_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            col     <= col_d;
            row     <= row_d;
            vsync_q <= vga_vsync;
        end
    end

    assign vs_rise = vga_vsync && !vsync_q;

    // Column of the pixel whose ROM data will arrive ROM_LAT cycles from the next cycle
    assign px       = col_d + CNT_W'(ROM_LAT);
    assign la_x_off = px - CNT_W'(X0);
    assign x_hit    = (la_x_off < CNT_W'(TILE));
    assign rel_row  = row_d - CNT_W'(Y0);

    // Tile index and tile top/bottom row decode by constant comparisons (no divider)
    always_comb begin
        // NOTE: every output of this block is given a default first, so no latch can be inferred.
        la_tile     = '0;
        y_hit       = 1'b0;
        la_tile_top = 1'b0;
        la_tile_bot = 1'b0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            if (rel_row < CNT_W'((k + 1) * TILE)) begin
                la_tile     = TW'(k);
                y_hit       = 1'b1;
                la_tile_top = (rel_row == CNT_W'(k * TILE));
                la_tile_bot = (rel_row == CNT_W'((k + 1) * TILE - 1));
            end
        end
    end

    assign la_win     = x_hit && y_hit;
    assign la_row_end = x_hit && (la_x_off == CNT_W'(TILE - 1));

endmodule

// File: rtl/digit_overlay_ctrl.sv
// Digit-glyph overlay scheduler: glyph ROM address generation ahead of the pixel,
// tag pipeline aligned to ROM latency, and a tear-free result commit FSM.
module digit_overlay_ctrl
    import ovl_pkg::*;
#(
    parameter int H_ACT   = DEF_H_ACT,
    parameter int X0      = DEF_X0,
    parameter int Y0      = DEF_Y0,
    parameter int TILE    = DEF_TILE,
    parameter int NUM_DIG = DEF_NUM_DIG,
    parameter int ROM_LAT = DEF_ROM_LAT,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                   sclk,
    input  logic                   s_rst_n,
    input  logic                   vga_vsync,
    input  logic                   vga_hsync,
    input  logic                   active_video,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [1:0]             res_slot,
    input  logic [3:0]             res_digit,
    input  logic                   res_last,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [3:0]             glyph_sel,
    output logic                   ovl_en,
    output logic [4*NUM_DIG-1:0]   disp_digits
);

    localparam int TW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    logic             vs_rise;
    logic             la_win;
    logic [TW-1:0]    la_tile;
    logic             la_tile_top;
    logic             la_tile_bot;
    logic             la_row_end;
    logic [CNT_W-1:0] la_x_off;

    ovl_raster_cnt #(
        .H_ACT   (H_ACT),
        .X0      (X0),
        .Y0      (Y0),
        .TILE    (TILE),
        .NUM_DIG (NUM_DIG),
        .ROM_LAT (ROM_LAT),
        .TW      (TW)
    ) u_raster (
        .sclk         (sclk),
        .s_rst_n      (s_rst_n),
        .vga_vsync    (vga_vsync),
        .vga_hsync    (vga_hsync),
        .active_video (active_video),
        .vs_rise      (vs_rise),
        .la_win       (la_win),
        .la_tile      (la_tile),
        .la_tile_top  (la_tile_top),
        .la_tile_bot  (la_tile_bot),
        .la_row_end   (la_row_end),
        .la_x_off     (la_x_off)
    );

    // ------------------------------------------------------------------
    // Address generator: row base accumulates TILE per tile row
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] base_cur;

    // A tile's first row always starts from base 0
    assign base_cur = la_tile_top ? '0 : line_base;

    // ROM address and row base registers
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rom_addr  <= '0;
            line_base <= '0;
        end else if (vga_vsync) begin
            rom_addr  <= '0;
            line_base <= '0;
        end else if (la_win) begin
            rom_addr <= base_cur + ADDR_W'(la_x_off);
            if (la_row_end) begin
                line_base <= la_tile_bot ? '0 : base_cur + ADDR_W'(TILE);
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: stage 0 sits beside rom_addr, stage ROM_LAT meets the ROM data
    // ------------------------------------------------------------------
    ovl_tag_t issue_tag;
    ovl_tag_t tag_sr [ROM_LAT+1];

    // Tag for the pixel being addressed next cycle
    always_comb begin
        issue_tag = TAG_NONE;
        if (la_win) begin
            issue_tag.en    = 1'b1;
            issue_tag.glyph = glyph_of(disp_digits[{la_tile, 2'b00} +: 4]);
        end
    end

    // Shift the tag along with the ROM read latency
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            // NOTE: this short array is reset in full so ovl_en is clean straight out of reset.
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_sr[i] <= TAG_NONE;
            end
        end else begin
            tag_sr[0] <= issue_tag;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign ovl_en    = tag_sr[ROM_LAT].en;
    assign glyph_sel = tag_sr[ROM_LAT].glyph;

    // ------------------------------------------------------------------
    // Result FSM: collect a batch into the shadow, commit it on vsync
    // ------------------------------------------------------------------
    res_state_t           state;
    res_state_t           state_nxt;
    logic                 accept;
    logic                 commit;
    logic [4*NUM_DIG-1:0] shadow;
    logic [4*NUM_DIG-1:0] shadow_nxt;

    assign accept = res_valid && res_ready;

    // Next state, commit strobe and shadow update
    always_comb begin
        state_nxt  = state;
        commit     = 1'b0;
        shadow_nxt = shadow;
        if (accept) begin
            // A new batch starts from what is on screen, so unwritten slots are kept
            if (state == ST_IDLE) begin
                shadow_nxt = disp_digits;
            end
            if (32'(res_slot) < NUM_DIG) begin
                shadow_nxt[{res_slot, 2'b00} +: 4] = res_digit;
            end
        end
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = res_last ? ST_PENDING : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept && res_last) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (vs_rise) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; ready is registered so it reads 0 throughout reset
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= ST_IDLE;
            res_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            res_ready <= (state_nxt != ST_PENDING);
        end
    end

    // Shadow batch and committed display digits
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            shadow      <= {NUM_DIG{GLYPH_BLANK}};
            disp_digits <= {NUM_DIG{GLYPH_BLANK}};
        end else begin
            shadow <= shadow_nxt;
            if (commit) begin
                disp_digits <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_digit_overlay_ctrl.sv
// Self-checking bench for digit_overlay_ctrl: a frame-level behavioural model compared
// every cycle, plus literal expectations at the raster points and batch boundaries.
module tb_digit_overlay_ctrl;

    localparam int H_ACT   = 480;
    localparam int X0      = 428;
    localparam int Y0      = 0;
    localparam int TILE    = 50;
    localparam int NUM_DIG = 4;
    localparam int ROM_LAT = 2;
    localparam int ADDR_W  = 14;

    logic              sclk         = 1'b0;
    logic              s_rst_n      = 1'b0;
    logic              vga_vsync    = 1'b0;
    logic              vga_hsync    = 1'b0;
    logic              active_video = 1'b0;
    logic              res_valid    = 1'b0;
    logic [1:0]        res_slot     = 2'd0;
    logic [3:0]        res_digit    = 4'd0;
    logic              res_last     = 1'b0;
    logic              res_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        glyph_sel;
    logic              ovl_en;
    logic [15:0]       disp_digits;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    digit_overlay_ctrl #(
        .H_ACT(H_ACT), .X0(X0), .Y0(Y0), .TILE(TILE),
        .NUM_DIG(NUM_DIG), .ROM_LAT(ROM_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .sclk         (sclk),
        .s_rst_n      (s_rst_n),
        .vga_vsync    (vga_vsync),
        .vga_hsync    (vga_hsync),
        .active_video (active_video),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_slot     (res_slot),
        .res_digit    (res_digit),
        .res_last     (res_last),
        .rom_addr     (rom_addr),
        .glyph_sel    (glyph_sel),
        .ovl_en       (ovl_en),
        .disp_digits  (disp_digits)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int         m_col, m_row, n_col, n_row, m_addr;
    logic       m_vs_prev, m_ready, m_open, m_pending;
    logic [3:0] m_disp   [NUM_DIG];
    logic [3:0] m_shadow [NUM_DIG];
    logic       vs_edge, acc, exp_en;
    logic [3:0] exp_glyph;
    bit         lit_on = 1'b0;

    function automatic bit in_win(input int c, input int r);
        return (c >= X0) && (c < X0 + TILE) && (r >= Y0) && (r < Y0 + NUM_DIG * TILE);
    endfunction

    function automatic logic [3:0] shown(input logic [3:0] d);
        return (d > 4'd9) ? 4'hF : d;
    endfunction

    always @(posedge sclk) begin
        if (!s_rst_n) begin
            m_col = 0; m_row = 0; m_addr = 0;
            m_vs_prev = 1'b0; m_ready = 1'b0; m_open = 1'b0; m_pending = 1'b0;
            for (int i = 0; i < NUM_DIG; i++) begin
                m_disp[i]   = 4'hF;
                m_shadow[i] = 4'hF;
            end
        end else begin
            vs_edge = vga_vsync && !m_vs_prev;
            acc     = res_valid && m_ready;
            if (m_pending && vs_edge) begin
                m_disp    = m_shadow;
                m_pending = 1'b0;
            end else if (acc) begin
                if (!m_open) begin
                    m_shadow = m_disp;
                    m_open   = 1'b1;
                end
                m_shadow[res_slot] = res_digit;
                if (res_last) begin
                    m_open    = 1'b0;
                    m_pending = 1'b1;
                end
            end
            m_ready   = !m_pending;
            m_vs_prev = vga_vsync;
            n_row = vga_vsync ? 0 : ((active_video && m_col == H_ACT - 1) ? m_row + 1 : m_row);
            n_col = vga_hsync ? 0 : (active_video ? m_col + 1 : m_col);
            m_col = n_col;
            m_row = n_row;
            if (vga_vsync) begin
                m_addr = 0;
            end else if (in_win(m_col + ROM_LAT, m_row)) begin
                m_addr = ((m_row - Y0) % TILE) * TILE + (m_col + ROM_LAT - X0);
            end
        end
        #1;
        exp_en    = in_win(m_col, m_row);
        exp_glyph = exp_en ? shown(m_disp[(m_row - Y0) / TILE]) : 4'hF;
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        check("ovl_en", 32'(ovl_en), 32'(exp_en));
        check("glyph_sel", 32'(glyph_sel), 32'(exp_glyph));
        check("res_ready", 32'(res_ready), 32'(m_ready));
        check("disp_digits", 32'(disp_digits), 32'({m_disp[3], m_disp[2], m_disp[1], m_disp[0]}));
        if (lit_on) begin
            if (m_row == 0 && m_col == 426)  check("r0_c426_addr", 32'(rom_addr), 32'd0);
            if (m_row == 0 && m_col == 427)  check("r0_c427_addr", 32'(rom_addr), 32'd1);
            if (m_row == 0 && m_col == 427)  check("r0_c427_ovl", 32'(ovl_en), 32'd0);
            if (m_row == 0 && m_col == 428)  check("r0_c428_ovl", 32'(ovl_en), 32'd1);
            if (m_row == 1 && m_col == 426)  check("r1_c426_addr", 32'(rom_addr), 32'd50);
            if (m_row == 49 && m_col == 475) check("r49_last_addr", 32'(rom_addr), 32'd2499);
            if (m_row == 50 && m_col == 426) check("r50_c426_addr", 32'(rom_addr), 32'd0);
            if (m_row == 10 && m_col == 440) check("glyph_row10", 32'(glyph_sel), 32'h3);
            if (m_row == 60 && m_col == 440) check("glyph_row60", 32'(glyph_sel), 32'h7);
            if (m_row == 110 && m_col == 440) check("glyph_row110", 32'(glyph_sel), 32'hF);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: one call = one clock cycle, driven on the falling edge
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0] slot;
        logic [3:0] digit;
        logic       last;
    } beat_t;

    beat_t beat_q[$];
    logic  rdy_at_drive = 1'b0;
    logic  rst_drv      = 1'b0;

    task automatic cycle(input logic hs, input logic vs, input logic av);
        if (res_valid && rdy_at_drive && beat_q.size() > 0) void'(beat_q.pop_front());
        s_rst_n      = rst_drv;
        vga_hsync    = hs;
        vga_vsync    = vs;
        active_video = av;
        if (beat_q.size() > 0) begin
            res_valid = 1'b1;
            res_slot  = beat_q[0].slot;
            res_digit = beat_q[0].digit;
            res_last  = beat_q[0].last;
        end else begin
            res_valid = 1'b0;
            res_last  = 1'b0;
        end
        rdy_at_drive = res_ready;
        @(negedge sclk);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge sclk);

        // Reset held across two frames
        rst_drv = 1'b0;
        repeat (2) begin
            repeat (3) line(20);
            vsync_pulse();
        end
        check("rst_ready", 32'(res_ready), 32'd0);
        check("rst_disp", 32'(disp_digits), 32'hFFFF);
        rst_drv = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("ready_after_rst", 32'(res_ready), 32'd1);

        // Frame A: batch mid-frame, committed only at the vsync edge
        line(20);
        beat_q.push_back('{slot: 2'd0, digit: 4'd3, last: 1'b0});
        beat_q.push_back('{slot: 2'd1, digit: 4'd7, last: 1'b0});
        beat_q.push_back('{slot: 2'd3, digit: 4'd9, last: 1'b1});
        line(20);
        line(20);
        check("batchA_drained", 32'(beat_q.size()), 32'd0);
        check("batchA_pending_ready", 32'(res_ready), 32'd0);
        check("batchA_before_vs", 32'(disp_digits), 32'hFFFF);
        vsync_pulse();
        check("batchA_committed", 32'(disp_digits), 32'h9F73);

        // Frame B: last beat accepted on the vsync edge itself
        line(20);
        line(20);
        beat_q.push_back('{slot: 2'd2, digit: 4'd12, last: 1'b1});
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("batchB_drained", 32'(beat_q.size()), 32'd0);
        check("batchB_no_commit", 32'(disp_digits), 32'h9F73);
        check("batchB_pending_ready", 32'(res_ready), 32'd0);
        line(20);
        line(20);
        check("batchB_still_old", 32'(disp_digits), 32'h9F73);
        vsync_pulse();
        check("batchB_committed", 32'(disp_digits), 32'h9C73);

        // Frame C: full-width lines through tiles 0..2, reset mid-batch at row 120
        lit_on = 1'b1;
        for (int r = 0; r < 120; r++) line(H_ACT);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1);
        beat_q.push_back('{slot: 2'd0, digit: 4'd1, last: 1'b0});
        beat_q.push_back('{slot: 2'd1, digit: 4'd2, last: 1'b0});
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1);
        check("collect_drained", 32'(beat_q.size()), 32'd0);
        check("collect_ready", 32'(res_ready), 32'd1);
        lit_on = 1'b0;
        rst_drv = 1'b0;
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        check("midrst_disp", 32'(disp_digits), 32'hFFFF);
        check("midrst_ready", 32'(res_ready), 32'd0);
        check("midrst_ovl", 32'(ovl_en), 32'd0);
        check("midrst_glyph", 32'(glyph_sel), 32'hF);
        check("midrst_addr", 32'(rom_addr), 32'd0);
        rst_drv = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        line(20);
        line(20);
        vsync_pulse();
        line(20);
        check("partial_never_shown", 32'(disp_digits), 32'hFFFF);
        check("idle_after_rst", 32'(res_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
